// File: rtl/uart_pkg.sv
// Shared types and helpers for the AXIS UART receive path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: receiver state enum, default oversampling ratio, tick divider calculation.
package uart_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;

    // PARITY is only reachable when AXIS_UART_RX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_tick_div(input int clkrate, input int baud, input int oversample);
        return (clkrate + (baud * oversample) / 2) / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every TICK_DIV clocks.
// Latency: first tick TICK_DIV clocks after the restart cycle.
// Backpressure: none; free-running apart from synchronous restart.
// Ports: clk, rstn (sync active-low), restart (re-phase the divider), tick (1-cycle pulse).
module uart_baud_tick #(
    parameter int TICK_DIV = 27
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Suppressed on the restart cycle so the next tick lands TICK_DIV clocks later.
    assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/axis_uart_rx.sv
// UART receiver (8N1, or 8E1 with AXIS_UART_RX_PARITY_EN) presenting words on an AXI-Stream master.
// Latency: m_axis_valid rises one clock after the stop-bit sample cycle.
// Backpressure: one-word holding register; a word completing while it is stalled is dropped and flagged on overrun.
// Ports: clk, rstn (sync active-low), UART_RX (async line, idle high), m_axis_data/valid/ready,
//        frame_err, overrun (and parity_err when AXIS_UART_RX_PARITY_EN is defined), all pulses one cycle wide.
module axis_uart_rx
    import uart_pkg::*;
#(
    parameter int CLKRATE     = 50000000,
    parameter int BAUD        = 115200,
    parameter int WORD_LENGTH = 8,
    parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   UART_RX,
    output logic [WORD_LENGTH-1:0] m_axis_data,
    output logic                   m_axis_valid,
    input  logic                   m_axis_ready,
`ifdef AXIS_UART_RX_PARITY_EN
    output logic                   parity_err,
`endif
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int             TICK_DIV = calc_tick_div(CLKRATE, BAUD, OVERSAMPLE);
    localparam int             TW       = $clog2(OVERSAMPLE + 1);
    localparam int             BW       = $clog2(WORD_LENGTH + 1);
    localparam logic [TW-1:0]  HALF_BIT = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0]  FULL_BIT = TW'(OVERSAMPLE);
    localparam logic [BW-1:0]  LAST_BIT = BW'(WORD_LENGTH - 1);

    generate
        if (TICK_DIV < 1) begin : g_bad_tick_div
            $error("axis_uart_rx: CLKRATE too low for BAUD*OVERSAMPLE");
        end
        if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_bad_oversample
            $error("axis_uart_rx: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    // ---------------- line synchroniser and start-edge detect ----------------
    logic       rx_meta, rx_sync, rx_prev, armed, start_edge;
    logic [1:0] fill;

    // The synchroniser resets to 1, so its first real sample could look like a
    // falling edge. 'armed' only rises once a genuine high has been seen, so a
    // line held low through reset is never mistaken for a start bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            fill    <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_meta <= UART_RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            fill    <= {fill[0], 1'b1};
            if (fill[1] && rx_sync) begin
                armed <= 1'b1;
            end
        end
    end

    assign start_edge = armed && rx_prev && !rx_sync;

    // ---------------- tick generator ----------------
    logic tick, restart;

    uart_baud_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .rstn    (rstn),
        .restart (restart),
        .tick    (tick)
    );

    // ---------------- frame FSM ----------------
    rx_state_t              state, state_nxt;
    logic [TW-1:0]          tick_cnt, tick_cnt_nxt, tick_inc;
    logic [BW-1:0]          bit_cnt, bit_cnt_nxt;
    logic [WORD_LENGTH-1:0] shreg, shreg_nxt;
    logic                   stop_sample, word_ok;
`ifdef AXIS_UART_RX_PARITY_EN
    logic                   par_bit, par_bit_nxt, par_bad;
`endif

    assign tick_inc = tick_cnt + TW'(1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef AXIS_UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
`ifdef AXIS_UART_RX_PARITY_EN
            par_bit  <= par_bit_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        restart      = 1'b0;
        stop_sample  = 1'b0;
`ifdef AXIS_UART_RX_PARITY_EN
        par_bit_nxt  = par_bit;
`endif
        case (state)
            IDLE: begin
                if (start_edge) begin
                    restart      = 1'b1;
                    tick_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                    state_nxt    = START;
                end
            end
            START: begin
                if (tick) begin
                    tick_cnt_nxt = tick_inc;
                    // Mid start bit: a high line here was a glitch.
                    if (tick_inc == HALF_BIT) begin
                        tick_cnt_nxt = '0;
                        state_nxt    = rx_sync ? IDLE : DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tick_cnt_nxt = tick_inc;
                    if (tick_inc == FULL_BIT) begin
                        tick_cnt_nxt = '0;
                        shreg_nxt    = {rx_sync, shreg[WORD_LENGTH-1:1]};
                        bit_cnt_nxt  = bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT) begin
`ifdef AXIS_UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end
                    end
                end
            end
`ifdef AXIS_UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tick_cnt_nxt = tick_inc;
                    if (tick_inc == FULL_BIT) begin
                        tick_cnt_nxt = '0;
                        par_bit_nxt  = rx_sync;
                        state_nxt    = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    tick_cnt_nxt = tick_inc;
                    if (tick_inc == FULL_BIT) begin
                        tick_cnt_nxt = '0;
                        stop_sample  = 1'b1;
                        state_nxt    = rx_sync ? IDLE : BREAK;
                    end
                end
            end
            BREAK: begin
                // Held-low line: stay here so only one frame_err is raised.
                if (rx_sync) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- status pulses ----------------
`ifdef AXIS_UART_RX_PARITY_EN
    assign par_bad    = ^{shreg, par_bit};
    assign parity_err = stop_sample && par_bad;
    assign word_ok    = stop_sample && rx_sync && !par_bad;
`else
    assign word_ok    = stop_sample && rx_sync;
`endif
    assign frame_err  = stop_sample && !rx_sync;
    assign overrun    = word_ok && m_axis_valid && !m_axis_ready;

    // ---------------- output holding register ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
        end else if (word_ok && (!m_axis_valid || m_axis_ready)) begin
            m_axis_valid <= 1'b1;
            m_axis_data  <= shreg;
        end else if (m_axis_valid && m_axis_ready) begin
            m_axis_valid <= 1'b0;
        end
    end

endmodule
